// File: rtl/jedro_1_data_mem.sv
// Byte-writable single-port data memory with load/store alignment for the jedro_1 core.
// Stores land on the request edge; loads return aligned, extended data one cycle later.
module jedro_1_data_mem #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [1:0]            size_i,
   input  logic                  unsigned_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rvalid_o,
   output logic                  err_o
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [31:0]      mem [DEPTH];
   logic [IDX_W-1:0] idx_p0;
   logic [1:0]       off_p0;
   logic             legal_p0;
   logic [3:0]       be_p0;
   logic [31:0]      wdata_rep_p0;
   logic             wr_en_p0;
   logic             rd_en_p0;

   logic [31:0]      word_p1;
   logic [1:0]       size_p1;
   logic [1:0]       off_p1;
   logic             uns_p1;
   logic             vld_p1;
   logic             err_p1;
   logic [31:0]      rdata_q;

   logic             unused_addr;

   // Shift the selected lane down and fill the upper bits with sign or zeros.
   function automatic logic [31:0] align_ext(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
      logic [31:0] sh;
      sh = w >> {off, 3'b000};
      case (size)
         2'b00:   align_ext = {{24{~uns & sh[7]}}, sh[7:0]};
         2'b01:   align_ext = {{16{~uns & sh[15]}}, sh[15:0]};
         default: align_ext = sh;
      endcase
   endfunction

   // Stage p0: request decode
   assign idx_p0      = addr_i[IDX_W+1:2];
   assign off_p0      = addr_i[1:0];
   assign unused_addr = ^{addr_i[ADDR_WIDTH-1:IDX_W+2]};

   always_comb begin
      legal_p0     = 1'b0;
      be_p0        = 4'b1111;
      wdata_rep_p0 = wdata_i;
      case (size_i)
         2'b00: begin
            legal_p0     = 1'b1;
            be_p0        = 4'b0001 << off_p0;
            wdata_rep_p0 = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            legal_p0     = ~off_p0[0];
            be_p0        = 4'b0011 << off_p0;
            wdata_rep_p0 = {2{wdata_i[15:0]}};
         end
         2'b10:   legal_p0 = (off_p0 == 2'b00);
         default: legal_p0 = 1'b0;
      endcase
   end

   assign wr_en_p0 = req_i & we_i  & legal_p0 & ~rst_i;
   assign rd_en_p0 = req_i & ~we_i & legal_p0 & ~rst_i;

   always_ff @(posedge clk_i) begin
      if (wr_en_p0) begin
         for (int k = 0; k < 4; k++) begin
            if (be_p0[k]) mem[idx_p0][8*k +: 8] <= wdata_rep_p0[8*k +: 8];
         end
      end
      if (rd_en_p0) word_p1 <= mem[idx_p0];
   end

   // Stage p1: response and control state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p1  <= 1'b0;
         err_p1  <= 1'b0;
         size_p1 <= 2'b00;
         off_p1  <= 2'b00;
         uns_p1  <= 1'b0;
         rdata_q <= '0;
      end else begin
         vld_p1 <= rd_en_p0;
         err_p1 <= req_i & ~legal_p0;
         if (rd_en_p0) begin
            size_p1 <= size_i;
            off_p1  <= off_p0;
            uns_p1  <= unsigned_i;
         end
         if (vld_p1) rdata_q <= rdata_o;
      end
   end

   assign rdata_o  = vld_p1 ? align_ext(word_p1, size_p1, off_p1, uns_p1) : rdata_q;
   assign rvalid_o = vld_p1;
   assign err_o    = err_p1;

endmodule

// File: tb/tb_jedro_1_data_mem.sv
// Directed bench for jedro_1_data_mem: each step pushes its expected response to a
// scoreboard queue, which is popped and checked right after the request edge.
module tb_jedro_1_data_mem;

   localparam int KIND_NONE = 0;
   localparam int KIND_LOAD = 1;
   localparam int KIND_ERR  = 2;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [1:0]  size_i = 2'b00;
   logic        unsigned_i = 1'b0;
   logic [31:0] wdata_i = '0;
   logic [31:0] rdata_o;
   logic        rvalid_o;
   logic        err_o;

   typedef struct {
      int          kind;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] last_rdata = '0;

   jedro_1_data_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .req_i      (req_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .size_i     (size_i),
      .unsigned_i (unsigned_i),
      .wdata_i    (wdata_i),
      .rdata_o    (rdata_o),
      .rvalid_o   (rvalid_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   task automatic step(input string tag, input logic rs, input logic r, input logic we,
                       input logic [31:0] a, input logic [1:0] sz, input logic u,
                       input logic [31:0] wd, input int kind, input logic [31:0] d);
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst_i = rs; req_i = r; we_i = we; addr_i = a; size_i = sz; unsigned_i = u; wdata_i = wd;
      e.kind = kind;
      if (kind == KIND_LOAD) e.data = d;
      else if (rs) e.data = 32'h0;
      else e.data = last_rdata;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      last_rdata = got.data;
      checks++;
      assert (rvalid_o === (got.kind == KIND_LOAD)) else begin
         failures++;
         $error("FAIL %s rvalid got=%b exp=%b", tag, rvalid_o, got.kind == KIND_LOAD);
      end
      checks++;
      assert (err_o === (got.kind == KIND_ERR)) else begin
         failures++;
         $error("FAIL %s err got=%b exp=%b", tag, err_o, got.kind == KIND_ERR);
      end
      checks++;
      assert (rdata_o === got.data) else begin
         failures++;
         $error("FAIL %s rdata got=%h exp=%h", tag, rdata_o, got.data);
      end
   endtask

   initial begin
      // reset
      step("rst0", 1, 0, 0, 32'h0, 2'b00, 0, 32'h0, KIND_NONE, 32'h0);
      step("rst1", 1, 0, 0, 32'h0, 2'b00, 0, 32'h0, KIND_NONE, 32'h0);
      step("idle", 0, 0, 0, 32'h0, 2'b00, 0, 32'h0, KIND_NONE, 32'h0);

      // half stores into zeroed words, back-to-back word loads
      step("pre0", 0, 1, 1, 32'h0, 2'b10, 0, 32'h0, KIND_NONE, 32'h0);
      step("pre4", 0, 1, 1, 32'h4, 2'b10, 0, 32'h0, KIND_NONE, 32'h0);
      step("sh0",  0, 1, 1, 32'h0, 2'b01, 0, 32'h0000FFFF, KIND_NONE, 32'h0);
      step("sh4",  0, 1, 1, 32'h4, 2'b01, 0, 32'h0000FFFF, KIND_NONE, 32'h0);
      step("lw0",  0, 1, 0, 32'h0, 2'b10, 0, 32'h0, KIND_LOAD, 32'h0000FFFF);
      step("lw4",  0, 1, 0, 32'h4, 2'b10, 0, 32'h0, KIND_LOAD, 32'h0000FFFF);

      // upper-half store keeps lower half
      step("pre0b", 0, 1, 1, 32'h0, 2'b10, 0, 32'h11223344, KIND_NONE, 32'h0);
      step("sh2",   0, 1, 1, 32'h2, 2'b01, 0, 32'h0000ABCD, KIND_NONE, 32'h0);
      step("lw0b",  0, 1, 0, 32'h0, 2'b10, 0, 32'h0, KIND_LOAD, 32'hABCD3344);

      // byte store and extension
      step("pre8", 0, 1, 1, 32'h8, 2'b10, 0, 32'h0, KIND_NONE, 32'h0);
      step("sb9",  0, 1, 1, 32'h9, 2'b00, 0, 32'h00000080, KIND_NONE, 32'h0);
      step("lb9",  0, 1, 0, 32'h9, 2'b00, 0, 32'h0, KIND_LOAD, 32'hFFFFFF80);
      step("lbu9", 0, 1, 0, 32'h9, 2'b00, 1, 32'h0, KIND_LOAD, 32'h00000080);
      step("lw8",  0, 1, 0, 32'h8, 2'b10, 0, 32'h0, KIND_LOAD, 32'h00008000);
      step("lh8",  0, 1, 0, 32'h8, 2'b01, 0, 32'h0, KIND_LOAD, 32'hFFFF8000);
      step("lhu8", 0, 1, 0, 32'h8, 2'b01, 1, 32'h0, KIND_LOAD, 32'h00008000);
      step("hold", 0, 0, 0, 32'h0, 2'b00, 0, 32'h0, KIND_NONE, 32'h0);

      // misaligned and illegal-size accesses
      step("sh1_err",  0, 1, 1, 32'h1, 2'b01, 0, 32'h00005555, KIND_ERR, 32'h0);
      step("sw6_err",  0, 1, 1, 32'h6, 2'b10, 0, 32'h66666666, KIND_ERR, 32'h0);
      step("ld11_err", 0, 1, 0, 32'h0, 2'b11, 0, 32'h0, KIND_ERR, 32'h0);
      step("lw0_keep", 0, 1, 0, 32'h0, 2'b10, 0, 32'h0, KIND_LOAD, 32'hABCD3344);
      step("lw4_keep", 0, 1, 0, 32'h4, 2'b10, 0, 32'h0, KIND_LOAD, 32'h0000FFFF);

      // address wrap at DEPTH*4
      step("sw_wrap",  0, 1, 1, 32'h1000, 2'b10, 0, 32'hDEADBEEF, KIND_NONE, 32'h0);
      step("lw_wrap",  0, 1, 0, 32'h0,    2'b10, 0, 32'h0, KIND_LOAD, 32'hDEADBEEF);
      step("lbu_wrap", 0, 1, 0, 32'h1003, 2'b00, 1, 32'h0, KIND_LOAD, 32'h000000DE);

      // load request during reset is dropped and rdata clears
      step("rst_ld",   1, 1, 0, 32'h0, 2'b10, 0, 32'h0, KIND_NONE, 32'h0);
      step("post_rst", 0, 0, 0, 32'h0, 2'b00, 0, 32'h0, KIND_NONE, 32'h0);
      step("st_rst",   1, 1, 1, 32'h0, 2'b10, 0, 32'h12345678, KIND_NONE, 32'h0);
      step("lw_after", 0, 1, 0, 32'h0, 2'b10, 0, 32'h0, KIND_LOAD, 32'hDEADBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jedro_1_data_mem.md
Name: jedro_1_data_mem

Overview:
- Single-port, byte-writable data memory for the jedro_1 core, with an integrated load/store alignment unit.
- Accepts one core load/store request per cycle and maps byte, half-word and word accesses onto 32-bit word storage using per-byte write enables.
- Returns load data sign- or zero-extended, with 1-cycle latency.
- Sits between the core's data-memory master port and word-organised RAM.

Parameters:
- ADDR_WIDTH, 32, width of the byte address from the core.
- DATA_WIDTH, 32, word width; fixed at 32, other values unsupported.
- DEPTH, 1024, number of 32-bit words stored; power of two.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  1  access request valid this cycle.
- we_i  in  1  1 = store, 0 = load; sampled only when req_i=1.
- addr_i  in  ADDR_WIDTH  byte address.
- size_i  in  2  access size: 00 byte, 01 half-word, 10 word; 11 is illegal.
- unsigned_i  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata_o  out  32  load result, aligned and extended.
- rvalid_o  out  1  rdata_o valid; single-cycle pulse.
- err_o  out  1  misaligned or illegal-size access; single-cycle pulse.

Behaviour:
- Word index = addr_i[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4. Byte offset = addr_i[1:0].
- Storage: DEPTH x 32 array, little-endian. Byte k of a word occupies bits [8k+7:8k]. Contents are not affected by reset; initial contents are undefined, and preloading the array by hierarchy is permitted.
- Alignment check. The access is legal when any of these holds:
  - size 00, any offset;
  - size 01 with offset[0]=0;
  - size 10 with offset=00.
  Any other size/offset combination, including size 11, is illegal.
- Illegal access with req_i=1:
  - No write occurs and rvalid_o stays 0.
  - err_o=1 on the next cycle.
- Legal store (req_i=1, we_i=1): write occurs at the rising edge of the request cycle.
  - Byte enables:
    - byte: 0001 << offset;
    - half: 0011 << offset;
    - word: 1111.
  - Write data = wdata_i replicated into every lane: byte in all four lanes; half in both halves.
  - Only enabled bytes change; all other bytes keep their old value.
  - No rvalid_o is generated.
- Legal load (req_i=1, we_i=0): the word is read at the request edge.
  - On the following cycle, rvalid_o=1 and rdata_o holds:
    - byte: the selected byte at bits [7:0];
    - half: the selected half-word at bits [15:0];
    - word: the whole word.
  - Upper bits are filled with the MSB of the selected field when unsigned_i=0, and with zeros when unsigned_i=1.
  - size, offset and unsigned_i are registered with the request and used for extension on the response cycle.
- rdata_o holds its last value when rvalid_o=0.
- Ordering:
  - One access per cycle.
  - A load issued the cycle after a store to the same word returns the newly written data.
  - Back-to-back loads give back-to-back rvalid_o pulses.
- req_i=0: no state change; rvalid_o=0 and err_o=0 on the next cycle.
- Reset (rst_i=1 at a rising edge): rvalid_o=0, err_o=0, rdata_o=0, registered request state cleared.
  - A request presented while rst_i=1 is ignored: no write, no response.
  - A load pending when reset asserts produces no rvalid_o.

Test Plan:
1. Preload words 0 and 1 with 0. Store half (size 01) with wdata 0x0000FFFF to addr 0 and addr 4, then load both as words. Required: rdata 0x0000FFFF twice, each with rvalid_o one cycle after its request.
2. Preload word 0 with 0x11223344. Store half 0xABCD at addr 2, then load word at addr 0. Required: 0xABCD3344.
3. Store byte 0x80 at addr 9, where word 2 is preloaded with 0.
   - Signed byte load at addr 9: 0xFFFFFF80.
   - Unsigned byte load at addr 9: 0x00000080.
   - Word load at addr 8: 0x00008000.
4. Misaligned accesses: store half at addr 1, store word at addr 6, and load with size 11. Required: err_o pulses on each, memory is unchanged, and no rvalid_o is generated.
5. Wrap: with DEPTH=1024, store word 0xDEADBEEF at addr 0x1000, then load addr 0. Required: 0xDEADBEEF.
6. Assert rst_i in the same cycle as a load request. Required: no rvalid_o, and rdata_o=0 after reset.
